// File: rtl/led_pkg.sv
// Shared types and default sizing for the LED fade/PWM driver.
package led_pkg;

    typedef enum logic [1:0] {
        FS_OFF     = 2'd0,
        FS_RISING  = 2'd1,
        FS_ON      = 2'd2,
        FS_FALLING = 2'd3
    } fade_state_t;

    localparam int LED_N_DEF    = 5;
    localparam int LEVEL_W_DEF  = 4;
    localparam int FADE_DIV_DEF = 16;

    // Prescaler counter width; a divide-by-one prescaler still needs one bit.
    function automatic int step_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/led_fade_pwm_if.sv
// Pattern/control inputs and LED drive outputs of the fade driver.
interface led_fade_pwm_if
    import led_pkg::*;
#(
    parameter int N_LEDS = LED_N_DEF
);
    logic [N_LEDS-1:0] pattern_in;
    logic              fade_en;
    logic [N_LEDS-1:0] led_out;
    logic              busy;

    modport master (
        output pattern_in,
        output fade_en,
        input  led_out,
        input  busy
    );

    modport slave (
        input  pattern_in,
        input  fade_en,
        output led_out,
        output busy
    );
endinterface

// File: rtl/led_fade_channel.sv
// One LED fade channel: ramp FSM, saturating brightness level and PWM compare.
module led_fade_channel
    import led_pkg::*;
#(
    parameter int LEVEL_W = LEVEL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               target,
    input  logic               fade_en,
    input  logic               step_stb,
    input  logic [LEVEL_W-1:0] pwm_cnt,
    output logic               led,
    output logic               ramping
);

    localparam logic [LEVEL_W-1:0] MAX_LEVEL = {LEVEL_W{1'b1}};
    localparam logic [LEVEL_W-1:0] ZERO_LVL  = {LEVEL_W{1'b0}};
    localparam logic [LEVEL_W-1:0] ONE_LVL   = LEVEL_W'(1);

    fade_state_t        state_r;
    fade_state_t        state_s;
    logic [LEVEL_W-1:0] level_r;
    logic [LEVEL_W-1:0] level_s;
    logic               led_r;

    // Next brightness level: snap when fading is off, else one saturating step per strobe
    always_comb begin
        level_s = level_r;
        if (!fade_en) begin
            level_s = target ? MAX_LEVEL : ZERO_LVL;
        end else if (step_stb && target && (level_r != MAX_LEVEL)) begin
            level_s = level_r + ONE_LVL;
        end else if (step_stb && !target && (level_r != ZERO_LVL)) begin
            level_s = level_r - ONE_LVL;
        end else begin
            level_s = level_r;
        end
    end

    // Next ramp state; settling is judged on the level being written this cycle
    always_comb begin
        state_s = state_r;
        if (!fade_en) begin
            state_s = target ? FS_ON : FS_OFF;
        end else begin
            case (state_r)
                FS_OFF: begin
                    if (target) begin
                        state_s = (level_s == MAX_LEVEL) ? FS_ON : FS_RISING;
                    end else begin
                        state_s = FS_OFF;
                    end
                end
                FS_ON: begin
                    if (target) begin
                        state_s = FS_ON;
                    end else begin
                        state_s = (level_s == ZERO_LVL) ? FS_OFF : FS_FALLING;
                    end
                end
                FS_RISING, FS_FALLING: begin
                    if (target) begin
                        state_s = (level_s == MAX_LEVEL) ? FS_ON : FS_RISING;
                    end else begin
                        state_s = (level_s == ZERO_LVL) ? FS_OFF : FS_FALLING;
                    end
                end
                default: begin
                    state_s = FS_OFF;
                end
            endcase
        end
    end

    // State, level and registered PWM drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= FS_OFF;
            level_r <= ZERO_LVL;
            led_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            level_r <= level_s;
            led_r   <= (level_r > pwm_cnt);
        end
    end

    assign led     = led_r;
    assign ramping = (state_s == FS_RISING) || (state_s == FS_FALLING);

endmodule

// File: rtl/led_fade_pwm.sv
// LED fade driver: pattern capture, shared PWM counter and fade prescaler, per-LED channels.
module led_fade_pwm
    import led_pkg::*;
#(
    parameter int N_LEDS   = LED_N_DEF,
    parameter int LEVEL_W  = LEVEL_W_DEF,
    parameter int FADE_DIV = FADE_DIV_DEF
) (
    input  logic           clk,
    input  logic           rst,
    led_fade_pwm_if.slave  bus
);

    localparam int                 STEP_W    = step_w(FADE_DIV);
    localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(FADE_DIV - 1);
    localparam logic [STEP_W-1:0]  STEP_ONE  = STEP_W'(1);
    localparam logic [LEVEL_W-1:0] PWM_LAST  = {LEVEL_W{1'b1}} - LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0] PWM_ONE   = LEVEL_W'(1);

    logic [N_LEDS-1:0]  pattern_r;
    logic [LEVEL_W-1:0] pwm_cnt_r;
    logic [STEP_W-1:0]  step_cnt_r;
    logic               busy_r;
    logic               step_stb_s;
    logic [N_LEDS-1:0]  led_s;
    logic [N_LEDS-1:0]  ramping_s;

    assign step_stb_s = (step_cnt_r == STEP_LAST);

    // Pattern capture, PWM period counter (MAX_LEVEL clocks) and fade prescaler
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_r  <= {N_LEDS{1'b0}};
            pwm_cnt_r  <= {LEVEL_W{1'b0}};
            step_cnt_r <= {STEP_W{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            pattern_r  <= bus.pattern_in;
            pwm_cnt_r  <= (pwm_cnt_r == PWM_LAST) ? {LEVEL_W{1'b0}} : (pwm_cnt_r + PWM_ONE);
            step_cnt_r <= step_stb_s ? {STEP_W{1'b0}} : (step_cnt_r + STEP_ONE);
            busy_r     <= |ramping_s;
        end
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
        led_fade_channel #(
            .LEVEL_W (LEVEL_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .target   (pattern_r[i]),
            .fade_en  (bus.fade_en),
            .step_stb (step_stb_s),
            .pwm_cnt  (pwm_cnt_r),
            .led      (led_s[i]),
            .ramping  (ramping_s[i])
        );
    end

    assign bus.led_out = led_s;
    assign bus.busy    = busy_r;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench: default and minimal (LEVEL_W=2, FADE_DIV=1) instances driven in lockstep against a level-tracking model.
module tb_led_fade_pwm;
    import led_pkg::*;

    localparam int NL = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    led_fade_pwm_if #(.N_LEDS(NL)) bus0 ();
    led_fade_pwm_if #(.N_LEDS(NL)) bus1 ();

    led_fade_pwm #(.N_LEDS(NL), .LEVEL_W(4), .FADE_DIV(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    led_fade_pwm #(.N_LEDS(NL), .LEVEL_W(2), .FADE_DIV(1)) u_dut_small (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: each LED level walks toward its target, one unit per prescaler strobe
    int              max_l [2] = '{15, 3};
    int              div_l [2] = '{16, 1};
    int              lvl   [2][NL];
    int              pwm   [2];
    int              stp   [2];
    logic [NL-1:0]   pq    [2];
    logic [NL-1:0]   led_m [2];
    logic            busy_m[2];

    logic [NL-1:0]   cur_pat;
    logic            cur_fe;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NL; i++) lvl[d][i] = 0;
            pwm[d] = 0; stp[d] = 0; pq[d] = '0; led_m[d] = '0; busy_m[d] = 1'b0;
        end
    endtask

    task automatic model_clock(input logic [NL-1:0] pin, input logic fe);
        for (int d = 0; d < 2; d++) begin
            logic stb;
            logic bz;
            stb = (stp[d] == div_l[d] - 1);
            bz  = 1'b0;
            for (int i = 0; i < NL; i++) begin
                int goal;
                led_m[d][i] = (lvl[d][i] > pwm[d]);
                goal = pq[d][i] ? max_l[d] : 0;
                if (!fe) lvl[d][i] = goal;
                else if (stb && lvl[d][i] < goal) lvl[d][i] = lvl[d][i] + 1;
                else if (stb && lvl[d][i] > goal) lvl[d][i] = lvl[d][i] - 1;
                if (lvl[d][i] != goal) bz = 1'b1;
            end
            busy_m[d] = bz;
            pwm[d] = (pwm[d] + 1) % max_l[d];
            stp[d] = (stp[d] + 1) % div_l[d];
            pq[d]  = pin;
        end
    endtask

    task automatic set_in(input logic [NL-1:0] p, input logic fe);
        cur_pat = p; cur_fe = fe;
        bus0.pattern_in = p; bus0.fade_en = fe;
        bus1.pattern_in = p; bus1.fade_en = fe;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset();
        else model_clock(cur_pat, cur_fe);
        @(negedge clk);
        check_eq("led0", 32'(bus0.led_out), 32'(led_m[0]));
        check_eq("busy0", 32'(bus0.busy), 32'(busy_m[0]));
        check_eq("led1", 32'(bus1.led_out), 32'(led_m[1]));
        check_eq("busy1", 32'(bus1.busy), 32'(busy_m[1]));
    endtask

    task automatic wait_level(input int goal, input int budget, input string tag);
        int n;
        logic hit;
        n = 0; hit = 1'b0;
        while (!hit && n < budget) begin
            if (lvl[0][0] == goal) hit = 1'b1;
            else begin cyc(); n++; end
        end
        check_eq(tag, 32'(hit), 32'd1);
    endtask

    task automatic duty_window(input int exp_hi, input string tag);
        int hi;
        hi = 0;
        repeat (15) begin cyc(); hi += int'(bus0.led_out[0]); end
        check_eq(tag, 32'(hi), 32'(exp_hi));
    endtask

    task automatic async_reset_check(input string tag);
        #2 rst = 1'b1;
        #1;
        check_eq({tag, "_led0"}, 32'(bus0.led_out), 32'd0);
        check_eq({tag, "_busy0"}, 32'(bus0.busy), 32'd0);
        check_eq({tag, "_led1"}, 32'(bus1.led_out), 32'd0);
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic seen;
        set_in(5'b11111, 1'b1);
        #1 rst = 1'b1;
        #1;
        check_eq("rst_led0", 32'(bus0.led_out), 32'd0);
        check_eq("rst_busy0", 32'(bus0.busy), 32'd0);
        model_reset();
        repeat (4) cyc();

        // Release with all targets on, snap mode, then reset asynchronously from all-on
        rst = 1'b0;
        set_in(5'b11111, 1'b0);
        repeat (6) cyc();
        check_eq("allon_led0", 32'(bus0.led_out), 32'h1f);
        async_reset_check("async_rst");
        repeat (2) cyc();
        rst = 1'b0;

        // Snap: led_out follows two edges after capture, busy stays low
        set_in(5'b00000, 1'b0);
        repeat (5) cyc();
        set_in(5'b10101, 1'b0);
        cyc();
        cyc();
        check_eq("snap_latency", 32'(bus0.led_out), 32'd0);
        repeat (30) begin
            cyc();
            check_eq("snap_led0", 32'(bus0.led_out), 32'h15);
            check_eq("snap_led1", 32'(bus1.led_out), 32'h15);
            check_eq("snap_busy", 32'(bus0.busy), 32'd0);
        end

        // Fade up: full ramp duration and steady-on afterwards
        set_in(5'b00000, 1'b0);
        repeat (5) cyc();
        set_in(5'b00001, 1'b1);
        cyc();
        n = 0; seen = 1'b0;
        do begin
            cyc(); n++;
            if (bus0.busy) seen = 1'b1;
        end while (bus0.busy && n < 400);
        check_eq("fade_busy_seen", 32'(seen), 32'd1);
        check_eq("fade_time", 32'((n >= 224) && (n <= 256)), 32'd1);
        repeat (20) begin
            cyc();
            check_eq("fade_full_on", 32'(bus0.led_out[0]), 32'd1);
        end

        // Reverse mid-ramp at level 8: no jump, then down to off
        set_in(5'b00000, 1'b0);
        repeat (5) cyc();
        set_in(5'b00001, 1'b1);
        wait_level(8, 300, "rev_reach8");
        set_in(5'b00000, 1'b1);
        wait_level(7, 60, "rev_reach7");
        duty_window(7, "rev_duty7");
        n = 0;
        do begin cyc(); n++; end while (bus0.busy && n < 400);
        check_eq("rev_done_busy", 32'(bus0.busy), 32'd0);
        repeat (16) begin
            cyc();
            check_eq("rev_off_led", 32'(bus0.led_out[0]), 32'd0);
        end

        // Reset mid-ramp at level 5: ramp restarts from 0
        set_in(5'b00001, 1'b1);
        wait_level(5, 200, "mid_reach5");
        async_reset_check("mid_rst");
        repeat (3) cyc();
        rst = 1'b0;
        wait_level(1, 60, "restart_reach1");
        duty_window(1, "restart_duty1");

        // Random traffic on both instances
        repeat (2500) begin
            logic [NL-1:0] p;
            logic fe;
            p = cur_pat; fe = cur_fe;
            if ($urandom_range(0, 19) == 0) p = NL'($urandom);
            if ($urandom_range(0, 59) == 0) fe = ($urandom_range(0, 3) != 0);
            set_in(p, fe);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
